// File: rtl/wt_store_wbuf.sv
// wt_store_wbuf: word-granular store write buffer between the store unit and the
// write-through dcache memory port.
//
// Stores (32-bit, byte enables) are merged into the youngest pending entry when they hit the
// same word. Otherwise they allocate a new entry. Entries go to memory in allocation order,
// and each one is tagged with its own index as the transaction ID. An entry retires
// individually when its write completion returns. A load-hazard lookup covers every valid
// entry.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   flush_i               block new stores, let the buffer drain
//   flush_done_o          flush_i and buffer empty
//   st_valid_i/ready_o    store handshake
//   st_addr_i/data_i/be_i store byte address (bits [1:0] ignored), lane-aligned data, byte enables
//   st_nc_i               non-idempotent store: never merged, never merged into
//   ld_addr_i, ld_hit_o   load word lookup against all valid entries
//   mem_req_o/gnt_i       write request handshake
//   mem_addr_o/data_o/be_o/tid_o  request fields, taken from the issue-pointer entry
//   mem_rtrn_vld_i/tid_i  write completion and its entry index
//   empty_o               no valid entry
module wt_store_wbuf #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TID_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                flush_done_o,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [XLEN-1:0]     st_data_i,
  input  logic [XLEN/8-1:0]   st_be_i,
  input  logic                st_nc_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [XLEN-1:0]     mem_data_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [TID_W-1:0]    mem_tid_o,
  input  logic                mem_rtrn_vld_i,
  input  logic [TID_W-1:0]    mem_rtrn_tid_i,
  output logic                empty_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BeW    = XLEN / 8;
  localparam int unsigned WaddrW = ADDR_W - 2;

  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Entry state: control bits carry reset, the payload does not.
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  iss_q, iss_d;
  logic [DEPTH-1:0]  nc_q, nc_d;
  logic [WaddrW-1:0] waddr_q [DEPTH];
  logic [WaddrW-1:0] waddr_d [DEPTH];
  logic [XLEN-1:0]   data_q  [DEPTH];
  logic [XLEN-1:0]   data_d  [DEPTH];
  logic [BeW-1:0]    be_q    [DEPTH];
  logic [BeW-1:0]    be_d    [DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              iss_ptr_q, iss_ptr_d;

  ptr_t              y_ptr;
  ptr_t              rtrn_idx;
  logic              merge_ok;
  logic              st_accept;
  logic              mem_fire;
  logic              rtrn_ok;
  logic [WaddrW-1:0] st_waddr;

  // The low address bits select a byte within the word and are not needed here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  assign st_waddr = st_addr_i[ADDR_W-1:2];
  assign y_ptr    = (wr_ptr_q == '0) ? ptr_t'(DEPTH - 1) : wr_ptr_q - ptr_t'(1);

  // Issue straight from the issue-pointer entry. The fields stay stable because that
  // entry is never merged into while it is being presented.
  assign mem_req_o  = vld_q[iss_ptr_q] & ~iss_q[iss_ptr_q];
  assign mem_addr_o = {waddr_q[iss_ptr_q], 2'b00};
  assign mem_data_o = data_q[iss_ptr_q];
  assign mem_be_o   = be_q[iss_ptr_q];
  assign mem_tid_o  = TID_W'(iss_ptr_q);
  assign mem_fire   = mem_req_o & mem_gnt_i;

  // Merging into an entry that is currently on the request bus would change fields
  // that memory may already be sampling, so that case allocates instead.
  assign merge_ok = vld_q[y_ptr] & ~iss_q[y_ptr] & ~nc_q[y_ptr] & ~st_nc_i &
                    (waddr_q[y_ptr] == st_waddr) &
                    ~((y_ptr == iss_ptr_q) & mem_req_o);

  assign st_ready_o = ~flush_i & (merge_ok | ~vld_q[wr_ptr_q]);
  assign st_accept  = st_valid_i & st_ready_o;

  // Returns for indices outside the buffer, or for entries that were not issued (for
  // example entries dropped by a reset), are ignored.
  assign rtrn_idx = ptr_t'(mem_rtrn_tid_i);
  assign rtrn_ok  = mem_rtrn_vld_i & (32'(mem_rtrn_tid_i) < DEPTH) &
                    vld_q[rtrn_idx] & iss_q[rtrn_idx];

  assign empty_o      = ~|vld_q;
  assign flush_done_o = flush_i & empty_o;

  always_comb begin
    ld_hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (waddr_q[i] == ld_addr_i[ADDR_W-1:2])) begin
        ld_hit_o = 1'b1;
      end
    end
  end

  // Accept, grant and return never target the same entry in one cycle, so they are
  // applied independently.
  always_comb begin
    vld_d     = vld_q;
    iss_d     = iss_q;
    nc_d      = nc_q;
    waddr_d   = waddr_q;
    data_d    = data_q;
    be_d      = be_q;
    wr_ptr_d  = wr_ptr_q;
    iss_ptr_d = iss_ptr_q;

    if (mem_fire) begin
      iss_d[iss_ptr_q] = 1'b1;
      iss_ptr_d        = ptr_inc(iss_ptr_q);
    end

    if (rtrn_ok) begin
      vld_d[rtrn_idx] = 1'b0;
      iss_d[rtrn_idx] = 1'b0;
    end

    if (st_accept) begin
      if (merge_ok) begin
        for (int unsigned b = 0; b < BeW; b++) begin
          if (st_be_i[b]) begin
            data_d[y_ptr][8*b +: 8] = st_data_i[8*b +: 8];
          end
        end
        be_d[y_ptr] = be_q[y_ptr] | st_be_i;
      end else begin
        vld_d[wr_ptr_q]   = 1'b1;
        iss_d[wr_ptr_q]   = 1'b0;
        nc_d[wr_ptr_q]    = st_nc_i;
        waddr_d[wr_ptr_q] = st_waddr;
        data_d[wr_ptr_q]  = st_data_i;
        be_d[wr_ptr_q]    = st_be_i;
        wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q     <= '0;
      iss_q     <= '0;
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
    end else begin
      vld_q     <= vld_d;
      iss_q     <= iss_d;
      wr_ptr_q  <= wr_ptr_d;
      iss_ptr_q <= iss_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    nc_q    <= nc_d;
    waddr_q <= waddr_d;
    data_q  <= data_d;
    be_q    <= be_d;
  end

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Scoreboard bench for wt_store_wbuf. Accepted stores are pushed into (or merged into) a
// queue of expected memory writes. A monitor compares the head of that queue with every
// request the DUT presents and pops it on grant. The reference model tracks slot
// occupancy, and it checks ready, hit, empty and flush_done every cycle.
module tb_wt_store_wbuf;
  localparam int DEPTH = 2;

  logic        clk = 1'b1;
  logic        rst_n, flush, flush_done;
  logic        st_valid, st_ready, st_nc;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [3:0]  st_be;
  logic        ld_hit, mem_req, mem_gnt, rtrn_vld, empty;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_be;
  logic [1:0]  mem_tid, rtrn_tid;

  wt_store_wbuf #(.DEPTH(DEPTH), .XLEN(32), .ADDR_W(32), .TID_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_done_o(flush_done),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_be_i(st_be), .st_nc_i(st_nc),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_tid_o(mem_tid),
    .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_tid_i(rtrn_tid), .empty_o(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        nc;
  } ent_t;

  ent_t        pend[$];          // accepted, not yet granted, in issue order
  bit          busy[DEPTH];
  bit          issued[DEPTH];
  logic [29:0] slot_waddr[DEPTH];
  int          wr;
  bit          popped;
  int          popped_idx;
  bit          last_acc;
  bit          chk_en;
  int          tests, fails;

  bit auto_en, garbage_en;
  int gnt_pct, rtrn_pct, ac;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < DEPTH; i++) if (busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: compares presented requests with the queue head and pops it on grant.
  always @(negedge clk) begin
    popped = 1'b0;
    if (chk_en && rst_n) begin
      check("mem_req", 32'(mem_req), 32'(pend.size() > 0));
      if (mem_req && pend.size() > 0) begin
        check("mem_addr", mem_addr, {pend[0].waddr, 2'b00});
        check("mem_data", mem_data, pend[0].data);
        check("mem_be", 32'(mem_be), 32'(pend[0].be));
        check("mem_tid", 32'(mem_tid), 32'(pend[0].idx));
        if (mem_gnt) begin
          popped         = 1'b1;
          popped_idx     = pend[0].idx;
          issued[popped_idx] = 1'b1;
          pend.delete(0);
        end
      end
    end
  end

  // Reference model: checks the per-cycle outputs, then applies the return and the
  // accept that the coming clock edge will perform.
  int   m_y, m_tid;
  bit   m_merge, m_rdy, m_hit;
  ent_t m_e;
  always @(negedge clk) begin
    #2;
    last_acc = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy[i]   = 1'b0;
        issued[i] = 1'b0;
      end
      pend.delete();
      wr = 0;
    end else if (chk_en) begin
      m_y     = (wr + DEPTH - 1) % DEPTH;
      m_merge = 1'b0;
      // The youngest entry is still waiting in the queue. It is not eligible while it is
      // the one being presented this cycle.
      if (pend.size() > 0 && (popped || pend.size() > 1)) begin
        if (pend[$].idx == m_y && !pend[$].nc && !st_nc && pend[$].waddr == st_addr[31:2])
          m_merge = 1'b1;
      end
      m_rdy = !flush && (m_merge || !busy[wr]);
      m_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (busy[i] && slot_waddr[i] == ld_addr[31:2]) m_hit = 1'b1;
      check("st_ready", 32'(st_ready), 32'(m_rdy));
      check("ld_hit", 32'(ld_hit), 32'(m_hit));
      check("empty", 32'(empty), 32'(model_empty()));
      check("flush_done", 32'(flush_done), 32'(flush && model_empty()));

      m_tid = int'(rtrn_tid);
      if (rtrn_vld && m_tid < DEPTH && busy[m_tid] && issued[m_tid] &&
          !(popped && popped_idx == m_tid)) begin
        busy[m_tid]   = 1'b0;
        issued[m_tid] = 1'b0;
      end

      if (st_valid && m_rdy) begin
        last_acc = 1'b1;
        if (m_merge) begin
          m_e = pend[pend.size()-1];
          for (int b = 0; b < 4; b++) if (st_be[b]) m_e.data[8*b +: 8] = st_data[8*b +: 8];
          m_e.be = m_e.be | st_be;
          pend[pend.size()-1] = m_e;
        end else begin
          m_e.idx   = wr;
          m_e.waddr = st_addr[31:2];
          m_e.data  = st_data;
          m_e.be    = st_be;
          m_e.nc    = st_nc;
          pend.push_back(m_e);
          busy[wr]       = 1'b1;
          issued[wr]     = 1'b0;
          slot_waddr[wr] = st_addr[31:2];
          wr             = (wr + 1) % DEPTH;
        end
      end
    end
  end

  // Random memory responder.
  always @(posedge clk) begin
    #1;
    if (auto_en) begin
      mem_gnt  = ($urandom_range(99) < gnt_pct);
      rtrn_vld = 1'b0;
      rtrn_tid = 2'd0;
      ac       = $urandom_range(DEPTH - 1);
      if ($urandom_range(99) < rtrn_pct && busy[ac] && issued[ac]) begin
        rtrn_vld = 1'b1;
        rtrn_tid = 2'(ac);
      end else if (garbage_en && $urandom_range(99) < 5) begin
        rtrn_vld = 1'b1;
        rtrn_tid = 2'($urandom_range(3));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    st_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic set_auto(input int g, input int r);
    auto_en  = 1'b1;
    gnt_pct  = g;
    rtrn_pct = r;
  endtask

  task automatic set_manual();
    @(posedge clk);
    #2;
    auto_en  = 1'b0;
    mem_gnt  = 1'b0;
    rtrn_vld = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic nc);
    bit done = 1'b0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_nc    = nc;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      if (last_acc) done = 1'b1;
      #1;
    end
    st_valid = 1'b0;
    st_nc    = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL store_accept: addr 0x%0h not accepted, required acceptance", a);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    set_auto(100, 100);
    for (int i = 0; i < 200 && !done; i++) begin
      if (model_empty() && pend.size() == 0) done = 1'b1;
      else tick();
    end
    tick();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain: buffer not empty after bound, required empty");
    end
  endtask

  logic [31:0] bases [4];

  initial begin
    bases[0] = 32'h0000_0040; bases[1] = 32'h0000_0044;
    bases[2] = 32'h1000_0040; bases[3] = 32'h0000_0080;
    tests = 0; fails = 0; chk_en = 1'b0; auto_en = 1'b0; garbage_en = 1'b0;
    gnt_pct = 0; rtrn_pct = 0;
    rst_n = 1'b0; flush = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    st_nc = 1'b0; ld_addr = '0; mem_gnt = 1'b0; rtrn_vld = 1'b0; rtrn_tid = '0;
    tick();
    do_reset();

    // Single store, issue, retire.
    set_auto(100, 100);
    store(32'h8000_0010, 32'h1122_3344, 4'hF, 1'b0);
    drain();

    // Merge into the youngest entry while the oldest entry is being presented, then full.
    do_reset();
    set_auto(0, 0);
    store(32'h0000_0100, 32'h0102_0304, 4'hF, 1'b0);
    store(32'h0000_0200, 32'hAABB_CCDD, 4'h3, 1'b0);
    store(32'h0000_0202, 32'h5566_0000, 4'hC, 1'b0);
    st_valid = 1'b1; st_addr = 32'h0000_0300; st_be = 4'hF;
    repeat (3) tick();
    st_valid = 1'b0;
    drain();

    // Non-idempotent stores to one word stay separate.
    do_reset();
    set_auto(0, 0);
    store(32'h0000_0040, 32'hDEAD_0001, 4'hF, 1'b1);
    store(32'h0000_0040, 32'hDEAD_0002, 4'h1, 1'b1);
    drain();

    // Out-of-order return leaves wr_ptr's slot occupied.
    do_reset();
    set_auto(100, 0);
    store(32'h0000_0010, 32'h0000_0010, 4'hF, 1'b0);
    store(32'h0000_0020, 32'h0000_0020, 4'hF, 1'b0);
    repeat (3) tick();
    set_manual();
    tick();
    rtrn_vld = 1'b1; rtrn_tid = 2'd1;
    tick();
    rtrn_vld = 1'b0;
    st_valid = 1'b1; st_addr = 32'h0000_0030; st_be = 4'hF;
    repeat (2) tick();
    st_valid = 1'b0;
    rtrn_vld = 1'b1; rtrn_tid = 2'd0;
    tick();
    rtrn_vld = 1'b0;
    set_auto(100, 100);
    store(32'h0000_0030, 32'h0000_0030, 4'hF, 1'b0);
    drain();

    // Load hazard on an issued but unreturned entry.
    do_reset();
    set_auto(100, 0);
    ld_addr = 32'h0000_0083;
    store(32'h0000_0080, 32'hCAFE_F00D, 4'hF, 1'b0);
    repeat (3) tick();
    ld_addr = 32'h0000_0084;
    tick();
    ld_addr = 32'h0000_0083;
    drain();
    repeat (2) tick();

    // Randomized traffic with flush windows and a mid-stream reset.
    set_auto(60, 40);
    garbage_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      st_valid = 1'($urandom_range(1));
      st_addr  = bases[$urandom_range(3)] | 32'($urandom_range(3));
      st_data  = $urandom;
      st_be    = 4'($urandom_range(15, 1));
      st_nc    = ($urandom_range(99) < 15);
      ld_addr  = bases[$urandom_range(3)] | 32'($urandom_range(3));
      if (i >= 2000 && i < 2040) flush = 1'b1;
      else if ($urandom_range(99) < 3) flush = ~flush;
      if (i == 1500) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    flush = 1'b1;
    st_valid = 1'b0;
    garbage_en = 1'b0;
    drain();
    flush = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
